uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_tx.sv | 125 ++++++++++++
 tb/tb_uart_tx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel-request / serial-line bundle between a frame producer and uart_tx.
// Ports: P_DATA, DATA_VALID, PAR_EN, PAR_TYP run producer -> transmitter; TX_OUT, Busy run back.
// The master modport is the producer side, the slave modport is the transmitter side.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serialises one DATA_WIDTH word per frame: start(0), data LSB first, optional parity, stop(1).
// Latency: start bit is on TX_OUT the cycle after the edge that samples DATA_VALID=1 in IDLE.
// Backpressure: DATA_VALID is only honoured in IDLE; requests while Busy are dropped, not queued.
// Ports: CLK bit clock, RST synchronous active-low reset, bus (slave modport) carries the
// word/valid/parity controls in and the registered TX_OUT / Busy outputs back.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q,   state_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic                  par_en_q,  par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q,      tx_d;
  logic                  busy_q,    busy_d;

  logic [IDX_W-1:0]      idx_nxt;

  assign idx_nxt = idx_q + IDX_W'(1);

  // tx_d / busy_d describe the line during the *next* state, so both outputs
  // come straight from flops while still lining up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.DATA_VALID) begin
          data_d    = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        idx_d   = '0;
        tx_d    = data_q[0];
        busy_d  = 1'b1;
      end
      DATA: begin
        busy_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          if (par_en_q) begin
            state_d = PARITY;
            // XOR gives even parity; folding in PAR_TYP inverts it for odd.
            tx_d    = (^data_q) ^ par_typ_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          idx_d = idx_nxt;
          tx_d  = data_q[idx_nxt];
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
      end
      STOP: begin
        // Always pass through IDLE so back-to-back frames get one idle bit.
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      data_q    <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized frames for uart_tx, checked bit by bit on the serial line.
module tb_uart_tx;

  logic clk;
  logic rst;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, parity chosen so that the count of
  // ones over data+parity is even (pt=0) or odd (pt=1), then stop 1.
  task automatic build_exp(input logic [7:0] w, input bit pe, input bit pt);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (pe) begin
      for (int p = 0; p < 2; p++)
        if (((ones + p) % 2) == int'(pt)) exp_q.push_back(p[0]);
    end
    exp_q.push_back(1'b1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".idle_tx"},   32'(bus.TX_OUT), 32'd1);
    chk({tag, ".idle_busy"}, 32'(bus.Busy),   32'd0);
  endtask

  // Request a frame and check every cycle of it against exp_q, then the idle bit after it.
  task automatic run_frame(input string tag, input logic [7:0] w, input bit pe, input bit pt,
                           input bit hold, input bit mid_chg, input logic [7:0] mid_w,
                           input bit mid_pe, input bit mid_pt, input bit stop_pulse);
    bus.P_DATA     = w;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.DATA_VALID = 1'b1;
    tick();
    if (!hold) bus.DATA_VALID = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      chk($sformatf("%s.tx[%0d]", tag, k),   32'(bus.TX_OUT), 32'(exp_q[k]));
      chk($sformatf("%s.busy[%0d]", tag, k), 32'(bus.Busy),   32'd1);
      if (k == 2 && mid_chg) begin
        bus.P_DATA  = mid_w;
        bus.PAR_EN  = mid_pe;
        bus.PAR_TYP = mid_pt;
      end
      if (k == exp_q.size() - 1 && stop_pulse) bus.DATA_VALID = 1'b1;
      tick();
      if (!hold) bus.DATA_VALID = 1'b0;
    end
    check_idle(tag);
  endtask

  initial begin
    logic [7:0] w;
    bit pe, pt, mpe, mpt;
    int gap;

    rst            = 1'b0;
    bus.P_DATA     = '0;
    bus.DATA_VALID = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b1;
    tick();
    check_idle("post_reset");

    // 0xA5, even parity, literal line sequence.
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 0x07, odd parity.
    exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_frame("07_odd", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 0xFF, no parity: 10-cycle frame.
    exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_frame("ff_nopar", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Held DATA_VALID: 0x55 intact despite P_DATA moving to 0x3C, then 0x3C after one idle bit.
    build_exp(8'h55, 1'b1, 1'b0);
    run_frame("held_55", 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    build_exp(8'h3C, 1'b1, 1'b0);
    run_frame("held_3c", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // DATA_VALID pulsed during STOP must not start a frame.
    build_exp(8'h96, 1'b0, 1'b0);
    run_frame("stop_pulse", 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    check_idle("stop_pulse_after");

    // Reset during data bit 4 truncates the frame; DATA_VALID during reset is ignored.
    w = 8'($urandom);
    bus.P_DATA     = w;
    bus.PAR_EN     = 1'b1;
    bus.PAR_TYP    = 1'b0;
    bus.DATA_VALID = 1'b1;
    tick();
    bus.DATA_VALID = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("rst_mid.bit4", 32'(bus.TX_OUT), 32'(w[4]));
    rst            = 1'b0;
    bus.DATA_VALID = 1'b1;
    tick();
    check_idle("rst_mid.r1");
    tick();
    check_idle("rst_mid.r2");
    rst = 1'b1;
    build_exp(8'h81, 1'b1, 1'b0);
    run_frame("after_rst_81", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Randomized frames with inputs scrambled mid-frame and random idle gaps.
    for (int n = 0; n < 24; n++) begin
      w   = 8'($urandom);
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      mpe = 1'($urandom);
      mpt = 1'($urandom);
      build_exp(w, pe, pt);
      run_frame($sformatf("rand%0d", n), w, pe, pt, 1'b0, 1'b1, 8'($urandom), mpe, mpt, 1'b0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        check_idle($sformatf("rand%0d.gap%0d", n, g));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
